// File: rtl/seg7_scan_decoder.sv
// Scan-bus receiver: waits for each multiplexed digit to settle, decodes it back to BCD
// and presents a complete frame on a valid/ready handshake. SEG7_ALT_GLYPH_EN adds alternate 6/7/9 glyphs.
module seg7_scan_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              Segment,
    input  logic [NUM_DIGITS-1:0]   Digit_Sel,
    input  logic                    Frame_Ready,
    output logic [4*NUM_DIGITS-1:0] BCD_Out,
    output logic [NUM_DIGITS-1:0]   Digit_Err,
    output logic                    Frame_Valid,
    output logic                    Overrun
);

    localparam logic [1:0] WAIT_D0    = 2'd0;
    localparam logic [1:0] CAPTURE    = 2'd1;
    localparam logic [1:0] FRAME_DONE = 2'd2;

    localparam logic [3:0] CNT_SAMPLE = 4'(STABLE_CYCLES - 1);
    localparam logic [2:0] LAST_IDX   = 3'(NUM_DIGITS - 1);

    logic [6:0]              seg_q, seg_p;
    logic [NUM_DIGITS-1:0]   sel_q, sel_p;
    logic [3:0]              cnt;
    logic                    armed;
    logic                    stable;
    logic                    fire;
    logic [2:0]              idx;
    logic [3:0]              code;
    logic                    glyph_err;

    logic [1:0]              state;
    logic [2:0]              exp_idx;
    logic [4*NUM_DIGITS-1:0] buf_bcd;
    logic [NUM_DIGITS-1:0]   buf_err;

    function automatic logic [3:0] glyph_decode(input logic [6:0] s);
        logic [3:0] d;
        case (s)
            7'b1111110: d = 4'd0;
            7'b0110000: d = 4'd1;
            7'b1101101: d = 4'd2;
            7'b1111001: d = 4'd3;
            7'b0110011: d = 4'd4;
            7'b1011011: d = 4'd5;
            7'b1011111: d = 4'd6;
            7'b1110000: d = 4'd7;
            7'b1111111: d = 4'd8;
            7'b1111011: d = 4'd9;
`ifdef SEG7_ALT_GLYPH_EN
            7'b0011111: d = 4'd6;
            7'b1110010: d = 4'd7;
            7'b1110011: d = 4'd9;
`endif
            default:    d = 4'hF;
        endcase
        return d;
    endfunction

    assign stable    = ({seg_q, sel_q} == {seg_p, sel_p}) && $onehot(sel_q);
    assign fire      = stable && armed && (cnt == CNT_SAMPLE);
    assign code      = glyph_decode(seg_q);
    assign glyph_err = (code == 4'hF);

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sel_q[i]) idx = 3'(i);
        end
    end

    // Counter saturates at the sample point; armed ensures one sample per settled digit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q <= '0;
            seg_p <= '0;
            sel_q <= '0;
            sel_p <= '0;
            cnt   <= '0;
            armed <= 1'b1;
        end else begin
            seg_q <= Segment;
            sel_q <= Digit_Sel;
            seg_p <= seg_q;
            sel_p <= sel_q;
            if (!stable) begin
                cnt   <= '0;
                armed <= 1'b1;
            end else begin
                if (cnt != CNT_SAMPLE) cnt <= cnt + 4'd1;
                if (fire) armed <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= WAIT_D0;
            exp_idx     <= '0;
            buf_bcd     <= '0;
            buf_err     <= '0;
            BCD_Out     <= '0;
            Digit_Err   <= '0;
            Frame_Valid <= 1'b0;
            Overrun     <= 1'b0;
        end else begin
            if (Frame_Valid && Frame_Ready) Frame_Valid <= 1'b0;

            case (state)
                WAIT_D0: begin
                    if (fire && idx == 3'd0) begin
                        buf_bcd <= {{(4*NUM_DIGITS-4){1'b0}}, code};
                        buf_err <= {{(NUM_DIGITS-1){1'b0}}, glyph_err};
                        exp_idx <= 3'd1;
                        state   <= (NUM_DIGITS == 1) ? FRAME_DONE : CAPTURE;
                    end
                end
                CAPTURE: begin
                    if (fire) begin
                        if (idx == exp_idx) begin
                            for (int i = 0; i < NUM_DIGITS; i++) begin
                                if (3'(i) == idx) begin
                                    buf_bcd[4*i +: 4] <= code;
                                    buf_err[i]        <= glyph_err;
                                end
                            end
                            exp_idx <= exp_idx + 3'd1;
                            if (idx == LAST_IDX) state <= FRAME_DONE;
                        end else if (idx == 3'd0) begin
                            // Out-of-order digit 0 restarts the frame rather than losing it.
                            buf_bcd <= {{(4*NUM_DIGITS-4){1'b0}}, code};
                            buf_err <= {{(NUM_DIGITS-1){1'b0}}, glyph_err};
                            exp_idx <= 3'd1;
                        end else begin
                            state <= WAIT_D0;
                        end
                    end
                end
                FRAME_DONE: begin
                    if (!Frame_Valid || Frame_Ready) begin
                        BCD_Out     <= buf_bcd;
                        Digit_Err   <= buf_err;
                        Frame_Valid <= 1'b1;
                    end else begin
                        Overrun <= 1'b1;
                    end
                    state <= WAIT_D0;
                end
                default: state <= WAIT_D0;
            endcase
        end
    end

endmodule
